// File: rtl/fixed_pkg.sv
// Shared constants and types for the IEEE-754 single to signed Q15.48 converter.
// Float field widths, the exponent-to-shift offset and the saturation constants live here.
package fixed_pkg;

  localparam int FIX_W   = 64;
  localparam int FRAC_W  = 48;
  localparam int FLT_W   = 32;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int MAG_W   = MAN_W + 1;
  localparam int SHMAG_W = FIX_W - 1;

  localparam int EXP_BIAS = 127;
  // A normal float is mag24 * 2^(e-127-23); scaling by 2^48 gives mag24 << (e-102).
  localparam logic signed [8:0] SHIFT_OFS = 9'(EXP_BIAS - FRAC_W + MAN_W);
  localparam logic [EXP_W-1:0]  OVF_EXP   = 8'd142;
  localparam logic [EXP_W-1:0]  EXP_MAX   = 8'd255;
  localparam logic signed [8:0] MAX_LSH   = 9'(SHMAG_W - MAG_W);

  localparam logic [FIX_W-1:0] SAT_POS = {1'b0, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W-1:0] SAT_NEG = {1'b1, {(FIX_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } float_cls_e;

  function automatic float_cls_e classify(input logic [EXP_W-1:0] exp_f,
                                          input logic [MAN_W-1:0] man_f);
    float_cls_e cls;
    if (exp_f == 8'd0) begin
      cls = ZERO;
    end else if (exp_f == EXP_MAX) begin
      cls = (man_f == 23'd0) ? INF : NAN;
    end else begin
      cls = NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fixed_shift.sv
// Combinational bidirectional barrel shifter: 24-bit magnitude shifted by a signed
// amount into a 63-bit magnitude; right shifts truncate toward zero.
module fixed_shift
  import fixed_pkg::*;
(
  input  logic [MAG_W-1:0]   mag_i,
  input  logic signed [8:0]  sh_i,
  output logic [SHMAG_W-1:0] mag_o
);

  logic [SHMAG_W-1:0] wide;
  logic signed [8:0]  neg_sh;

  always_comb begin
    wide   = {{(SHMAG_W-MAG_W){1'b0}}, mag_i};
    neg_sh = -sh_i;
    mag_o  = '0;
    if (sh_i >= 9'sd0) begin
      // Larger left shifts only occur for operands that saturate downstream.
      if (sh_i <= MAX_LSH) begin
        mag_o = wide << sh_i[5:0];
      end else begin
        mag_o = '0;
      end
    end else begin
      if (neg_sh >= 9'sd24) begin
        mag_o = '0;
      end else begin
        mag_o = wide >> neg_sh[4:0];
      end
    end
  end

endmodule

// File: rtl/float_to_fixed.sv
// Three-stage IEEE-754 single to signed Q15.48 converter with saturation and NaN flagging.
// The whole pipeline advances together; a stalled output freezes every stage.
module float_to_fixed
  import fixed_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLT_W-1:0] in_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FIX_W-1:0] out_fixed,
  output logic             out_ovf,
  output logic             out_nan
);

  logic adv;

  logic               v1_q, v1_d, sign1_q, sign1_d;
  logic [EXP_W-1:0]   exp1_q, exp1_d;
  logic [MAN_W-1:0]   man1_q, man1_d;
  float_cls_e         cls1_q, cls1_d;

  logic               v2_q, v2_d, sign2_q, sign2_d;
  logic               ovf2_q, ovf2_d, negmin2_q, negmin2_d;
  float_cls_e         cls2_q, cls2_d;
  logic [SHMAG_W-1:0] mag2_q, mag2_d;

  logic               out_valid_q, out_valid_d, out_ovf_q, out_ovf_d, out_nan_q, out_nan_d;
  logic [FIX_W-1:0]   out_fixed_q, out_fixed_d;

  logic signed [8:0]  sh;
  logic [SHMAG_W-1:0] shifted;
  logic               man_zero;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_fixed = out_fixed_q;
  assign out_ovf   = out_ovf_q;
  assign out_nan   = out_nan_q;

  assign sh       = $signed({1'b0, exp1_q}) - SHIFT_OFS;
  assign man_zero = (man1_q == 23'd0);

  fixed_shift u_shift (
    .mag_i (({1'b1, man1_q})),
    .sh_i  (sh),
    .mag_o (shifted)
  );

  // Stage 1 and 2 next-state: unpack/classify, then shift and range-check.
  always_comb begin
    v1_d      = v1_q;
    sign1_d   = sign1_q;
    exp1_d    = exp1_q;
    man1_d    = man1_q;
    cls1_d    = cls1_q;
    v2_d      = v2_q;
    sign2_d   = sign2_q;
    cls2_d    = cls2_q;
    ovf2_d    = ovf2_q;
    negmin2_d = negmin2_q;
    mag2_d    = mag2_q;
    if (adv) begin
      v1_d      = in_valid;
      sign1_d   = in_float[FLT_W-1];
      exp1_d    = in_float[FLT_W-2:MAN_W];
      man1_d    = in_float[MAN_W-1:0];
      cls1_d    = classify(in_float[FLT_W-2:MAN_W], in_float[MAN_W-1:0]);
      v2_d      = v1_q;
      sign2_d   = sign1_q;
      cls2_d    = cls1_q;
      mag2_d    = shifted;
      // -2^15 is the only magnitude at exponent 142 that fits the signed range.
      negmin2_d = (exp1_q == OVF_EXP) && sign1_q && man_zero;
      ovf2_d    = (exp1_q > OVF_EXP) || ((exp1_q == OVF_EXP) && !(sign1_q && man_zero));
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 3 next-state: apply sign, saturation and flags.
  always_comb begin
    out_valid_d = out_valid_q;
    out_fixed_d = out_fixed_q;
    out_ovf_d   = out_ovf_q;
    out_nan_d   = out_nan_q;
    if (adv) begin
      out_valid_d = v2_q;
      out_fixed_d = '0;
      out_ovf_d   = 1'b0;
      out_nan_d   = 1'b0;
      case (cls2_q)
        ZERO: begin
          out_fixed_d = '0;
        end
        NAN: begin
          out_nan_d = 1'b1;
        end
        INF: begin
          out_fixed_d = sign2_q ? SAT_NEG : SAT_POS;
          out_ovf_d   = 1'b1;
        end
        NORMAL: begin
          if (ovf2_q) begin
            out_fixed_d = sign2_q ? SAT_NEG : SAT_POS;
            out_ovf_d   = 1'b1;
          end else if (negmin2_q) begin
            out_fixed_d = SAT_NEG;
          end else begin
            out_fixed_d = sign2_q ? -{1'b0, mag2_q} : {1'b0, mag2_q};
          end
        end
        default: begin
          out_fixed_d = '0;
        end
      endcase
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      exp1_q      <= '0;
      man1_q      <= '0;
      cls1_q      <= ZERO;
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      cls2_q      <= ZERO;
      ovf2_q      <= 1'b0;
      negmin2_q   <= 1'b0;
      mag2_q      <= '0;
      out_valid_q <= 1'b0;
      out_fixed_q <= '0;
      out_ovf_q   <= 1'b0;
      out_nan_q   <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      sign1_q     <= sign1_d;
      exp1_q      <= exp1_d;
      man1_q      <= man1_d;
      cls1_q      <= cls1_d;
      v2_q        <= v2_d;
      sign2_q     <= sign2_d;
      cls2_q      <= cls2_d;
      ovf2_q      <= ovf2_d;
      negmin2_q   <= negmin2_d;
      mag2_q      <= mag2_d;
      out_valid_q <= out_valid_d;
      out_fixed_q <= out_fixed_d;
      out_ovf_q   <= out_ovf_d;
      out_nan_q   <= out_nan_d;
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// Self-checking bench for float_to_fixed: directed spec vectors, backpressure,
// random handshaking against a scoreboard model, and reset behaviour.
module tb_float_to_fixed;

  localparam logic [63:0]         SP   = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0]         SN   = 64'h8000_0000_0000_0000;
  localparam logic signed [127:0] MAXP = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MINN = -128'sh8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf, out_nan;
  logic [31:0] in_float;
  logic [63:0] out_fixed;

  int checks = 0;
  int errors = 0;

  logic [65:0] sb_q[$];
  logic        fire_in_s, fire_out_s;
  logic [65:0] obs;

  always #5 clk = ~clk;

  float_to_fixed dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fixed (out_fixed),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan)
  );

  // Reference: exact integer scaling by 2^48, then clamp to the 64-bit signed range.
  function automatic logic [65:0] model(input logic [31:0] f);
    logic s;
    logic [7:0] e;
    logic [22:0] m;
    logic signed [127:0] v;
    s = f[31];
    e = f[30:23];
    m = f[22:0];
    if (e == 8'd0) return 66'd0;
    if (e == 8'd255) return (m != 23'd0) ? {2'b10, 64'd0} : {2'b01, (s ? SN : SP)};
    if (e >= 8'd150) return {2'b01, (s ? SN : SP)};
    v = {104'd0, 1'b1, m};
    if (e >= 8'd102) v = v << (e - 8'd102);
    else v = v >> (8'd102 - e);
    if (s) v = -v;
    if (v > MAXP) return {2'b01, SP};
    if (v < MINN) return {2'b01, SN};
    return {2'b00, v[63:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0] e;
    int unsigned k;
    k = $urandom_range(0, 19);
    case (k)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'd142;
      3:       e = 8'd143;
      default: e = 8'($urandom_range(95, 146));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // One clock: sample handshakes mid-cycle, record accepted operands, step past the edge.
  task automatic tick();
    @(negedge clk);
    fire_in_s  = in_valid && in_ready && rst_n;
    fire_out_s = out_valid && out_ready && rst_n;
    obs        = {out_nan, out_ovf, out_fixed};
    if (fire_in_s) sb_q.push_back(model(in_float));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_float = 32'd0; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if ({out_nan, out_ovf, out_fixed} !== 66'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {out_nan, out_ovf, out_fixed});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] din[14];
    logic [65:0] dexp[14];
    int lat;
    bit got;
    din  = '{32'h3F800000, 32'hC0200000, 32'h27800000, 32'h27000000, 32'h80000000,
             32'h00000001, 32'h47800000, 32'hFF800000, 32'hC7000000, 32'h7FC00000,
             32'h47000000, 32'h46FFFFFF, 32'hC6FFFFFF, 32'h3F000000};
    dexp = '{{2'b00, 64'h0001_0000_0000_0000}, {2'b00, 64'hFFFD_8000_0000_0000},
             {2'b00, 64'h0000_0000_0000_0001}, 66'd0, 66'd0, 66'd0,
             {2'b01, 64'h7FFF_FFFF_FFFF_FFFF}, {2'b01, 64'h8000_0000_0000_0000},
             {2'b00, 64'h8000_0000_0000_0000}, {2'b10, 64'h0},
             {2'b01, 64'h7FFF_FFFF_FFFF_FFFF}, {2'b00, 64'h7FFF_FF80_0000_0000},
             {2'b00, 64'h8000_0080_0000_0000}, {2'b00, 64'h0000_8000_0000_0000}};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_float = din[i];
      tick();
      in_valid = 1'b0;
      checks++;
      if (!fire_in_s) begin errors++; $display("FAIL directed_accept[%0d] got=0 exp=1", i); end
      lat = 0; got = 1'b0;
      while (!got && lat < 8) begin
        tick();
        lat++;
        if (fire_out_s) got = 1'b1;
      end
      checks++;
      if (!got || lat != 3) begin
        errors++; $display("FAIL directed_latency[%0d] got=%0d exp=3 (seen=%0d)", i, lat, got);
      end
      checks++;
      if (obs !== dexp[i]) begin
        errors++; $display("FAIL directed_value[%0d] in=%h got=%h exp=%h", i, din[i], obs, dexp[i]);
      end
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vec[8];
    logic [65:0] exp_v;
    logic [63:0] held;
    int idx;
    int n_out;
    for (int i = 0; i < 8; i++) vec[i] = {1'(i[0]), 8'(112 + 3 * i), 23'($urandom)};
    idx = 0; n_out = 0; out_ready = 1'b1;
    while (n_out == 0 && idx < 8) begin
      in_valid = 1'b1; in_float = vec[idx];
      tick();
      if (fire_in_s) idx++;
      if (fire_out_s) begin
        n_out++;
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL bp_first got=%h exp=%h", obs, exp_v); end
      end
    end
    out_ready = 1'b0;
    in_float  = vec[idx];
    #1;
    held = out_fixed;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_fixed !== held || fire_in_s) begin
        errors++;
        $display("FAIL bp_stall[%0d] in_ready=%b out_valid=%b out_fixed=%h exp_held=%h", c, in_ready,
                 out_valid, out_fixed, held);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (idx < 8 || sb_q.size() > 0); c++) begin
      in_valid = (idx < 8); in_float = vec[idx % 8];
      tick();
      if (fire_in_s) idx++;
      if (fire_out_s) begin
        n_out++;
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", n_out, obs, exp_v); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_out != 8 || sb_q.size() != 0) begin
      errors++; $display("FAIL bp_count got=%0d exp=8 pending=%0d", n_out, sb_q.size());
    end
  endtask

  task automatic test_random();
    logic [65:0] exp_v;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_float  = rand_float();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (fire_out_s) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rand_extra got=%h exp=none", obs);
        end else begin
          exp_v = sb_q.pop_front();
          if (obs !== exp_v) begin errors++; $display("FAIL rand_value[%0d] got=%h exp=%h", c, obs, exp_v); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) begin
      tick();
      if (fire_out_s) begin
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rand_drain got=%h exp=%h", obs, exp_v); end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d pending exp=0", sb_q.size()); end
  endtask

  task automatic test_reset_midstream();
    int stray;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_float = 32'h3F800000 + 32'(i << 20);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_fill got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    checks++;
    if (out_valid !== 1'b0 || {out_nan, out_ovf, out_fixed} !== 66'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state out_valid=%b outs=%h in_ready=%b exp=0,0,1", out_valid,
               {out_nan, out_ovf, out_fixed}, in_ready);
    end
    out_ready = 1'b1;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (fire_out_s) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rst_mid_stale got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
